ysyx_041461_lsu: RTL and testbench
==================================

# ysyx_041461_lsu

Load/store stage between EXE and WB in the ysyx_041461 five-stage RV64 core. Accepts one instruction per handshake from EXE, performs at most one 64-bit-aligned data-bus transaction (held-request / ack protocol), then presents a single-cycle `WB_valid` pulse with the ALU result, load data and pass-through fields to WB. Load data is byte-lane extracted and sign/zero extended; store data and byte mask are lane-shifted.

## Interface
- No parameters; widths fixed (XLEN 64).
- `clk` in 1: the single clock; everything on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `EXE_valid` in 1: EXE offers an instruction.
- `EXE_ready` out 1: LSU accepts this cycle (transfer = valid & ready).
- `EXE_result` in 64: ALU result; effective address for memory ops.
- `EXE_store_data` in 64: rs2 value for stores.
- `EXE_mem_ctrl` in 4: 0 none, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, A SW, B SD; C–F = none.
- `EXE_rd` in 5, `EXE_rs1` in 5, `EXE_csr` in 12, `EXE_imm` in 64, `EXE_zimm` in 64, `EXE_pc` in 64, `EXE_wb_ctrl` in 4: pass-through to WB.
- `mem_req` out 1; `mem_wen` out 1; `mem_addr` out 64 (low 3 bits always 0); `mem_wdata` out 64; `mem_wmask` out 8 (bit i = byte i).
- `mem_ack` in 1: transaction complete; `mem_rdata` in 64: read data, valid with ack.
- `WB_valid` out 1; `WB_EXE_in` out 64; `WB_MEM_in` out 64; `WB_rd`/`WB_rs1` out 5; `WB_csr` out 12; `WB_imm`/`WB_zimm`/`WB_pc` out 64; `WB_ctrl` out 4.
- `mem_misalign` out 1: one-cycle pulse, misaligned access dropped.

## Operation
- States: IDLE, BUS. `EXE_ready` = (state == IDLE).
- IDLE, transfer, mem_ctrl none: register all fields; next cycle WB_valid=1, `WB_MEM_in`=0; stay IDLE.
- IDLE, transfer, memory op, aligned (H: addr[0]=0; W: addr[1:0]=0; D: addr[2:0]=0): latch fields, go BUS.
- IDLE, transfer, memory op, misaligned: no bus access; next cycle WB_valid=1 with `WB_ctrl` forced 4'h0 (NOP) and mem_misalign=1; stay IDLE.
- BUS: mem_req=1, mem_addr={addr[63:3],3'b0}, mem_wen=1 for stores; all bus outputs stable until ack. On mem_ack: loads capture extended data into `WB_MEM_in`; stores set it 0; WB_valid=1 next cycle; return to IDLE.
- Load extract: lane = mem_rdata >> (8*addr[2:0]); B/H/W take low 8/16/32 bits, sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU); LD takes all 64.
- Store: mem_wdata = store_data << (8*addr[2:0]); mem_wmask = {01,03,0F,FF}[size] << addr[2:0]. Loads: wmask=0, wdata=0.
- `WB_EXE_in` = EXE_result for every instruction; other WB fields = latched EXE fields.
- mem_ack while mem_req=0 ignored. EXE_valid while not ready ignored; EXE holds.

## Timing
- Reset: state IDLE; WB_valid, mem_req, mem_wen, mem_misalign = 0; mem_addr, mem_wdata, mem_wmask, all WB_* data = 0.
- Non-memory / misaligned: accepted cycle N → WB_valid high exactly cycle N+1.
- Memory: accepted N → mem_req high N+1 … ack cycle M (M ≥ N+1, ack same cycle as first req allowed) → mem_req low and WB_valid high M+1; EXE_ready low N+1..M, high M+1.
- Back-to-back non-memory: one instruction per cycle, WB_valid continuously high.
- WB_valid is a single-cycle pulse per instruction; WB_* fields valid only while WB_valid=1.
- rst mid-BUS: next cycle mem_req=0, state IDLE, no WB_valid; abandoned transaction's later ack ignored.

## Test plan
- Reset, then EXE add (mem_ctrl 0, result 0x1234, rd 5) → cycle+1 WB_valid=1, WB_EXE_in=0x1234, WB_rd=5, WB_MEM_in=0, mem_req never high.
- LB addr 0x8000_0003, ack after 3 cycles with rdata 0x0000_0000_80FF_0000 (byte3=0x80) → mem_addr 0x8000_0000, WB_MEM_in=0xFFFF_FFFF_FFFF_FF80; LBU same → 0x80; EXE_ready low for 3 cycles.
- SH addr 0x8000_0006, store_data 0xABCD, ack same cycle as req → wdata 0xABCD_0000_0000_0000, wmask 0xC0, wen=1, WB_valid two cycles after accept.
- LW addr 0x8000_0002 → no mem_req, mem_misalign pulse, WB_valid with WB_ctrl=0.
- Assert rst while mem_req high, then mem_ack → mem_req 0 after reset edge, WB_valid stays 0, new instruction accepted normally.
- Stray mem_ack in IDLE plus 8 back-to-back ALU ops → 8 consecutive WB_valid cycles, results in order, no state change.

Source files
------------

// File: rtl/ysyx_041461_lsu.sv
// ysyx_041461 load/store stage between EXE and WB.
// Ports: EXE_* handshake in, mem_* bus master, WB_* single-cycle result, mem_misalign pulse.
module ysyx_041461_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_valid,
    output logic        EXE_ready,
    input  logic [63:0] EXE_result,
    input  logic [63:0] EXE_store_data,
    input  logic [3:0]  EXE_mem_ctrl,
    input  logic [4:0]  EXE_rd,
    input  logic [4:0]  EXE_rs1,
    input  logic [11:0] EXE_csr,
    input  logic [63:0] EXE_imm,
    input  logic [63:0] EXE_zimm,
    input  logic [63:0] EXE_pc,
    input  logic [3:0]  EXE_wb_ctrl,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        WB_valid,
    output logic [63:0] WB_EXE_in,
    output logic [63:0] WB_MEM_in,
    output logic [4:0]  WB_rd,
    output logic [4:0]  WB_rs1,
    output logic [11:0] WB_csr,
    output logic [63:0] WB_imm,
    output logic [63:0] WB_zimm,
    output logic [63:0] WB_pc,
    output logic [3:0]  WB_ctrl,
    output logic        mem_misalign
);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t      r_state;
    logic [2:0]  r_off;
    logic [3:0]  r_mem_ctrl;

    // Access size: 0 byte, 1 half, 2 word, 3 double.
    function automatic logic [1:0] f_size(input logic [3:0] c);
        case (c)
            4'h1, 4'h5, 4'h8: f_size = 2'd0;
            4'h2, 4'h6, 4'h9: f_size = 2'd1;
            4'h3, 4'h7, 4'hA: f_size = 2'd2;
            default:          f_size = 2'd3;
        endcase
    endfunction

    logic        w_accept;
    logic        w_exe_load;
    logic        w_exe_store;
    logic [1:0]  w_exe_size;
    logic        w_misalign;
    logic [7:0]  w_mask_base;
    logic [7:0]  w_wmask;
    logic [63:0] w_wdata;
    logic        w_r_load;
    logic        w_r_uns;
    logic [63:0] w_lane;
    logic [63:0] w_load_data;

    assign EXE_ready   = (r_state == S_IDLE);
    assign w_accept    = EXE_valid && EXE_ready;
    assign w_exe_load  = (EXE_mem_ctrl >= 4'h1) && (EXE_mem_ctrl <= 4'h7);
    assign w_exe_store = (EXE_mem_ctrl >= 4'h8) && (EXE_mem_ctrl <= 4'hB);
    assign w_exe_size  = f_size(EXE_mem_ctrl);
    assign w_wmask     = w_mask_base << EXE_result[2:0];
    assign w_wdata     = EXE_store_data << {EXE_result[2:0], 3'b000};
    assign w_r_load    = (r_mem_ctrl >= 4'h1) && (r_mem_ctrl <= 4'h7);
    assign w_r_uns     = (r_mem_ctrl >= 4'h5) && (r_mem_ctrl <= 4'h7);
    assign w_lane      = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_misalign  = 1'b0;
        w_mask_base = 8'hFF;
        case (w_exe_size)
            2'd0: w_mask_base = 8'h01;
            2'd1: begin
                w_mask_base = 8'h03;
                w_misalign  = EXE_result[0];
            end
            2'd2: begin
                w_mask_base = 8'h0F;
                w_misalign  = |EXE_result[1:0];
            end
            default: w_misalign = |EXE_result[2:0];
        endcase
    end

    // Sign bit is masked off for the unsigned load variants.
    always_comb begin
        w_load_data = w_lane;
        case (f_size(r_mem_ctrl))
            2'd0: w_load_data = {{56{w_lane[7] & ~w_r_uns}}, w_lane[7:0]};
            2'd1: w_load_data = {{48{w_lane[15] & ~w_r_uns}}, w_lane[15:0]};
            2'd2: w_load_data = {{32{w_lane[31] & ~w_r_uns}}, w_lane[31:0]};
            default: w_load_data = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_off        <= 3'd0;
            r_mem_ctrl   <= 4'd0;
            mem_req      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 64'd0;
            mem_wmask    <= 8'd0;
            mem_misalign <= 1'b0;
            WB_valid     <= 1'b0;
            WB_EXE_in    <= 64'd0;
            WB_MEM_in    <= 64'd0;
            WB_rd        <= 5'd0;
            WB_rs1       <= 5'd0;
            WB_csr       <= 12'd0;
            WB_imm       <= 64'd0;
            WB_zimm      <= 64'd0;
            WB_pc        <= 64'd0;
            WB_ctrl      <= 4'd0;
        end else begin
            WB_valid     <= 1'b0;
            mem_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        WB_EXE_in  <= EXE_result;
                        WB_MEM_in  <= 64'd0;
                        WB_rd      <= EXE_rd;
                        WB_rs1     <= EXE_rs1;
                        WB_csr     <= EXE_csr;
                        WB_imm     <= EXE_imm;
                        WB_zimm    <= EXE_zimm;
                        WB_pc      <= EXE_pc;
                        WB_ctrl    <= EXE_wb_ctrl;
                        r_off      <= EXE_result[2:0];
                        r_mem_ctrl <= EXE_mem_ctrl;
                        if (!(w_exe_load || w_exe_store)) begin
                            WB_valid <= 1'b1;
                        end else if (w_misalign) begin
                            // Dropped access retires as a NOP.
                            WB_valid     <= 1'b1;
                            WB_ctrl      <= 4'h0;
                            mem_misalign <= 1'b1;
                        end else begin
                            r_state   <= S_BUS;
                            mem_req   <= 1'b1;
                            mem_wen   <= w_exe_store;
                            mem_addr  <= {EXE_result[63:3], 3'b000};
                            mem_wdata <= w_exe_store ? w_wdata : 64'd0;
                            mem_wmask <= w_exe_store ? w_wmask : 8'd0;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        mem_req   <= 1'b0;
                        mem_wen   <= 1'b0;
                        WB_valid  <= 1'b1;
                        WB_MEM_in <= w_r_load ? w_load_data : 64'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_041461_lsu.sv
// Scoreboard bench for ysyx_041461_lsu.
// Stimulus pushes expected WB records; a negedge monitor pops and compares.
module tb_ysyx_041461_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_valid, EXE_ready;
    logic [63:0] EXE_result, EXE_store_data;
    logic [3:0]  EXE_mem_ctrl, EXE_wb_ctrl;
    logic [4:0]  EXE_rd, EXE_rs1;
    logic [11:0] EXE_csr;
    logic [63:0] EXE_imm, EXE_zimm, EXE_pc;
    logic        mem_req, mem_wen, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        WB_valid, mem_misalign;
    logic [63:0] WB_EXE_in, WB_MEM_in, WB_imm, WB_zimm, WB_pc;
    logic [4:0]  WB_rd, WB_rs1;
    logic [11:0] WB_csr;
    logic [3:0]  WB_ctrl;

    ysyx_041461_lsu dut (
        .clk(clk), .rst(rst),
        .EXE_valid(EXE_valid), .EXE_ready(EXE_ready),
        .EXE_result(EXE_result), .EXE_store_data(EXE_store_data),
        .EXE_mem_ctrl(EXE_mem_ctrl), .EXE_rd(EXE_rd),
        .EXE_rs1(EXE_rs1), .EXE_csr(EXE_csr), .EXE_imm(EXE_imm),
        .EXE_zimm(EXE_zimm), .EXE_pc(EXE_pc),
        .EXE_wb_ctrl(EXE_wb_ctrl),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .WB_valid(WB_valid), .WB_EXE_in(WB_EXE_in),
        .WB_MEM_in(WB_MEM_in), .WB_rd(WB_rd), .WB_rs1(WB_rs1),
        .WB_csr(WB_csr), .WB_imm(WB_imm), .WB_zimm(WB_zimm),
        .WB_pc(WB_pc), .WB_ctrl(WB_ctrl),
        .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] exe;
        logic [63:0] mem;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] zimm;
        logic [25:0] pass;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] pc_ctr = 64'h8000_0000;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] mc, input logic [63:0] res,
                         input logic [63:0] sd, input logic [4:0] rd);
        pc_ctr         = pc_ctr + 64'd4;
        EXE_valid      = 1'b1;
        EXE_mem_ctrl   = mc;
        EXE_result     = res;
        EXE_store_data = sd;
        EXE_rd         = rd;
        EXE_rs1        = rd ^ 5'h1F;
        EXE_csr        = pc_ctr[11:0] ^ 12'hA5A;
        EXE_imm        = ~pc_ctr;
        EXE_zimm       = pc_ctr ^ 64'h55;
        EXE_pc         = pc_ctr;
        EXE_wb_ctrl    = 4'h3 ^ mc;
    endtask

    task automatic push(input logic [63:0] mem_in, input logic nop);
        exp_t e;
        e.exe  = EXE_result;
        e.mem  = mem_in;
        e.pc   = EXE_pc;
        e.imm  = EXE_imm;
        e.zimm = EXE_zimm;
        e.pass = {EXE_rd, EXE_rs1, EXE_csr,
                  nop ? 4'h0 : EXE_wb_ctrl};
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && WB_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got WB_valid=1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_exe_in", WB_EXE_in, e.exe);
                chk("wb_mem_in", WB_MEM_in, e.mem);
                chk("wb_pc", WB_pc, e.pc);
                chk("wb_imm", WB_imm, e.imm);
                chk("wb_zimm", WB_zimm, e.zimm);
                chk("wb_pass", {38'd0, WB_rd, WB_rs1, WB_csr, WB_ctrl},
                    {38'd0, e.pass});
            end
        end
    end

    // Memory op with d request cycles; ack rises on the d-th one.
    task automatic mem_op(input logic [3:0] mc, input logic [63:0] addr,
                          input logic [63:0] sd, input logic [63:0] rdata,
                          input int d, input logic [63:0] exp_mem,
                          input logic [63:0] exp_wdata,
                          input logic [7:0] exp_mask,
                          input logic exp_wen);
        int lowcnt;
        @(negedge clk);
        drive(mc, addr, sd, 5'd7);
        push(exp_mem, 1'b0);
        @(negedge clk);
        EXE_valid = 1'b0;
        lowcnt = 0;
        chk("mem_addr", mem_addr, {addr[63:3], 3'b000});
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, exp_mask});
        chk("mem_wen", {63'd0, mem_wen}, {63'd0, exp_wen});
        for (int k = 1; k <= d; k++) begin
            chk("mem_req_hold", {63'd0, mem_req}, 64'd1);
            if (!EXE_ready) lowcnt++;
            if (k == d) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        end
        chk("mem_req_drop", {63'd0, mem_req}, 64'd0);
        chk("ready_back", {63'd0, EXE_ready}, 64'd1);
        chk("ready_low_cycles", 64'(lowcnt), 64'(d));
    endtask

    task automatic misalign_op(input logic [3:0] mc,
                               input logic [63:0] addr);
        @(negedge clk);
        drive(mc, addr, 64'h1111, 5'd9);
        push(64'd0, 1'b1);
        @(negedge clk);
        EXE_valid = 1'b0;
        chk("mis_req", {63'd0, mem_req}, 64'd0);
        chk("mis_pulse", {63'd0, mem_misalign}, 64'd1);
        @(negedge clk);
        chk("mis_pulse_end", {63'd0, mem_misalign}, 64'd0);
        chk("mis_req2", {63'd0, mem_req}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;
        drive(4'h0, 64'd0, 64'd0, 5'd0);
        EXE_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {63'd0, WB_valid}, 64'd0);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_wen", {63'd0, mem_wen}, 64'd0);
        chk("rst_mis", {63'd0, mem_misalign}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rst_wb_exe", WB_EXE_in, 64'd0);
        chk("rst_wb_pc", WB_pc, 64'd0);
        chk("rst_ready", {63'd0, EXE_ready}, 64'd1);
        rst = 1'b0;

        // Plain ALU op.
        @(negedge clk);
        drive(4'h0, 64'h1234, 64'h0, 5'd5);
        push(64'd0, 1'b0);
        @(negedge clk);
        EXE_valid = 1'b0;
        chk("alu_wb_valid", {63'd0, WB_valid}, 64'd1);
        chk("alu_req", {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        chk("alu_pulse_end", {63'd0, WB_valid}, 64'd0);

        // Codes C-F behave as no memory access.
        @(negedge clk);
        drive(4'hE, 64'h8000_0003, 64'h0, 5'd6);
        push(64'd0, 1'b0);
        @(negedge clk);
        EXE_valid = 1'b0;
        chk("ctrlE_req", {63'd0, mem_req}, 64'd0);

        // Loads.
        mem_op(4'h1, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 3,
               64'hFFFF_FFFF_FFFF_FF80, 64'd0, 8'h00, 1'b0);
        mem_op(4'h5, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 3,
               64'h0000_0000_0000_0080, 64'd0, 8'h00, 1'b0);
        mem_op(4'h2, 64'h8000_0002, 64'h0, 64'h0000_0000_F00D_0000, 1,
               64'hFFFF_FFFF_FFFF_F00D, 64'd0, 8'h00, 1'b0);
        mem_op(4'h6, 64'h8000_0002, 64'h0, 64'h0000_0000_F00D_0000, 2,
               64'h0000_0000_0000_F00D, 64'd0, 8'h00, 1'b0);
        mem_op(4'h3, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1,
               64'hFFFF_FFFF_8765_4321, 64'd0, 8'h00, 1'b0);
        mem_op(4'h7, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1,
               64'h0000_0000_8765_4321, 64'd0, 8'h00, 1'b0);
        mem_op(4'h4, 64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788, 2,
               64'h1122_3344_5566_7788, 64'd0, 8'h00, 1'b0);

        // Stores.
        mem_op(4'h9, 64'h8000_0006, 64'hABCD, 64'h0, 1,
               64'd0, 64'hABCD_0000_0000_0000, 8'hC0, 1'b1);
        mem_op(4'h8, 64'h8000_0015, 64'h5A, 64'h0, 2,
               64'd0, 64'h0000_5A00_0000_0000, 8'h20, 1'b1);
        mem_op(4'hA, 64'h8000_0004, 64'hDEAD_BEEF, 64'h0, 1,
               64'd0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1);
        mem_op(4'hB, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 2,
               64'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);

        // Misaligned accesses.
        misalign_op(4'h3, 64'h8000_0002);
        misalign_op(4'h9, 64'h8000_0001);
        misalign_op(4'h4, 64'h8000_0004);

        // Reset in the middle of a bus transaction.
        @(negedge clk);
        drive(4'h4, 64'h8000_0020, 64'h0, 5'd3);
        @(negedge clk);
        EXE_valid = 1'b0;
        chk("abort_req_hi", {63'd0, mem_req}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_lo", {63'd0, mem_req}, 64'd0);
        chk("abort_ready", {63'd0, EXE_ready}, 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 64'h7777;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("abort_wb", {63'd0, WB_valid}, 64'd0);
        chk("abort_req2", {63'd0, mem_req}, 64'd0);
        mem_op(4'h1, 64'h8000_0021, 64'h0, 64'h0000_0000_0000_4200, 1,
               64'h0000_0000_0000_0042, 64'd0, 8'h00, 1'b0);

        // Stray ack in IDLE across 8 back-to-back ALU ops.
        @(negedge clk);
        mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(4'h0, 64'h100 + 64'(i * 3), 64'h0, 5'(i + 1));
            push(64'd0, 1'b0);
            @(negedge clk);
            chk("b2b_wb_valid", {63'd0, WB_valid}, 64'd1);
            chk("b2b_req", {63'd0, mem_req}, 64'd0);
            chk("b2b_ready", {63'd0, EXE_ready}, 64'd1);
        end
        EXE_valid = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk);
        chk("b2b_end", {63'd0, WB_valid}, 64'd0);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
